exu_rx_ctrl: RTL and testbench

Packet-level controller that sequences the external UART receiver (`ExtUART_Rx`). It owns the receiver's baud configuration. It assembles received words into framed packets (header, fixed-length payload, checksum), validates them, and hands them downstream over a valid/ready handshake. Timeout, framing, checksum and overflow errors are counted and reported.

---
 rtl/exu_rx_ctrl.sv | 123 ++++++++++++
 tb/tb_exu_rx_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/exu_rx_ctrl.sv
// exu_rx_ctrl: frames receiver words into header/payload/checksum packets,
// hands them downstream over valid/ready and accounts for errors.
module exu_rx_ctrl #(
  parameter int         W_DAT   = 32,
  parameter int         W_BAU   = 8,
  parameter int         N_PLD   = 4,
  parameter logic [7:0] HDR_KEY = 8'hA5,
  parameter int         BAU_DEF = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [W_BAU-1:0]       cfg_baud,
  input  logic                   cfg_we,
  output logic [W_BAU-1:0]       baud,
  input  logic [W_DAT-1:0]       rx_dat,
  input  logic                   rx_fin,
  input  logic                   rx_tot,
  output logic [7:0]             pkt_cmd,
  output logic [N_PLD*W_DAT-1:0] pkt_dat,
  output logic                   pkt_vld,
  input  logic                   pkt_rdy,
  output logic                   bsy,
  output logic                   err_pls,
  output logic [1:0]             err_code,
  output logic [15:0]            cnt_ok,
  output logic [15:0]            cnt_err
);
  localparam int W_CTR = N_PLD > 1 ? $clog2(N_PLD) : 1;
  typedef enum logic [1:0] {IDLE, PLD, CHK, OUT} state_t;
  state_t                 r_state, w_nxt;
  logic [W_CTR-1:0]       r_ctr;
  logic [W_DAT-1:0]       r_sum;
  logic [W_DAT-1:0]       r_pld [N_PLD];
  logic [N_PLD*W_DAT-1:0] w_pld, r_pkt_dat;
  logic [7:0]             r_cmd, r_pkt_cmd;
  logic [W_BAU-1:0]       r_baud;
  logic                   r_err_pls;
  logic [1:0]             r_err_code, w_code;
  logic [15:0]            r_cnt_ok, r_cnt_err;
  logic                   w_fin, w_key, w_last, w_sum_ok, w_err, w_done;
  // a timeout pulse masks a coincident word
  assign w_fin    = rx_fin & ~rx_tot;
  assign w_key    = rx_dat[W_DAT-1 -: 8] == HDR_KEY;
  assign w_last   = r_ctr == W_CTR'(N_PLD - 1);
  assign w_sum_ok = rx_dat == r_sum;
  assign w_done   = r_state == OUT && pkt_rdy;
  for (genvar g = 0; g < N_PLD; g++) begin : g_pack
    assign w_pld[g*W_DAT +: W_DAT] = r_pld[g];
  end
  always_comb begin
    w_nxt  = r_state;
    w_err  = 1'b0;
    w_code = 2'd0;
    case (r_state)
      IDLE: begin
        w_nxt  = w_fin && w_key ? PLD : IDLE;
        w_err  = w_fin && !w_key;
        w_code = 2'd1;
      end
      PLD: begin
        w_nxt = rx_tot ? IDLE : w_fin && w_last ? CHK : PLD;
        w_err = rx_tot;
      end
      CHK: begin
        w_nxt  = rx_tot || (w_fin && !w_sum_ok) ? IDLE : w_fin ? OUT : CHK;
        w_err  = rx_tot || (w_fin && !w_sum_ok);
        w_code = rx_tot ? 2'd0 : 2'd2;
      end
      OUT: begin
        w_nxt  = pkt_rdy ? IDLE : OUT;
        w_err  = w_fin;
        w_code = 2'd3;
      end
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_baud     <= W_BAU'(BAU_DEF);
      r_ctr      <= '0;
      r_sum      <= '0;
      r_cmd      <= '0;
      r_pkt_cmd  <= '0;
      r_pkt_dat  <= '0;
      r_err_pls  <= 1'b0;
      r_err_code <= 2'd0;
      r_cnt_ok   <= '0;
      r_cnt_err  <= '0;
      for (int i = 0; i < N_PLD; i++) r_pld[i] <= '0;
    end else begin
      r_state   <= w_nxt;
      r_err_pls <= w_err;
      if (w_err) r_err_code <= w_code;
      if (w_err && r_cnt_err != 16'hFFFF) r_cnt_err <= r_cnt_err + 16'd1;
      if (w_done && r_cnt_ok != 16'hFFFF) r_cnt_ok <= r_cnt_ok + 16'd1;
      if (r_state == IDLE && cfg_we) r_baud <= cfg_baud < W_BAU'(2) ? W_BAU'(2) : cfg_baud;
      if (r_state == IDLE && w_fin && w_key) begin
        r_cmd <= rx_dat[7:0];
        r_ctr <= '0;
        r_sum <= '0;
      end
      if (r_state == PLD && w_fin) begin
        r_pld[r_ctr] <= rx_dat;
        r_sum        <= r_sum + rx_dat;
        r_ctr        <= r_ctr + 1'b1;
      end
      if (r_state == CHK && w_fin && w_sum_ok) begin
        r_pkt_dat <= w_pld;
        r_pkt_cmd <= r_cmd;
      end
    end
  end
  assign baud     = r_baud;
  assign pkt_cmd  = r_pkt_cmd;
  assign pkt_dat  = r_pkt_dat;
  assign pkt_vld  = r_state == OUT;
  assign bsy      = r_state != IDLE;
  assign err_pls  = r_err_pls;
  assign err_code = r_err_code;
  assign cnt_ok   = r_cnt_ok;
  assign cnt_err  = r_cnt_err;
endmodule

// File: tb/tb_exu_rx_ctrl.sv
// tb_exu_rx_ctrl: directed packets against a queue-based packet model,
// compared every cycle, plus hand-computed literal checkpoints.
module tb_exu_rx_ctrl;
  localparam int N = 2;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  cfg_baud = '0;
  logic        cfg_we = 1'b0;
  logic [7:0]  baud;
  logic [31:0] rx_dat = '0;
  logic        rx_fin = 1'b0;
  logic        rx_tot = 1'b0;
  logic [7:0]  pkt_cmd;
  logic [63:0] pkt_dat;
  logic        pkt_vld;
  logic        pkt_rdy = 1'b1;
  logic        bsy, err_pls;
  logic [1:0]  err_code;
  logic [15:0] cnt_ok, cnt_err;
  int n_run = 0;
  int n_fail = 0;

  exu_rx_ctrl #(.W_DAT(32), .W_BAU(8), .N_PLD(N), .HDR_KEY(8'hA5), .BAU_DEF(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_baud(cfg_baud), .cfg_we(cfg_we), .baud(baud),
    .rx_dat(rx_dat), .rx_fin(rx_fin), .rx_tot(rx_tot), .pkt_cmd(pkt_cmd),
    .pkt_dat(pkt_dat), .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy), .bsy(bsy),
    .err_pls(err_pls), .err_code(err_code), .cnt_ok(cnt_ok), .cnt_err(cnt_err));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // packet model: header opens a packet, N words are queued, the next word is the checksum
  logic [7:0]  m_baud = 8'd16;
  bit          m_in = 0, m_out = 0, m_err = 0;
  logic [1:0]  m_code = 2'd0;
  int          m_ok = 0, m_nerr = 0;
  logic [31:0] m_q [$];
  logic [7:0]  m_hcmd = '0, m_cmd = '0;
  logic [63:0] m_dat = '0;
  logic [31:0] m_sum;

  task automatic merr(input logic [1:0] c);
    m_err = 1;
    m_code = c;
    if (m_nerr < 65535) m_nerr++;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_baud = 8'd16; m_in = 0; m_out = 0; m_err = 0; m_code = 0;
      m_ok = 0; m_nerr = 0; m_hcmd = 0; m_cmd = 0; m_dat = 0;
      m_q.delete();
    end else begin
      m_err = 0;
      if (m_out) begin
        if (rx_fin && !rx_tot) merr(2'd3);
        if (pkt_rdy) begin
          m_out = 0;
          if (m_ok < 65535) m_ok++;
        end
      end else if (!m_in) begin
        if (cfg_we) m_baud = cfg_baud < 8'd2 ? 8'd2 : cfg_baud;
        if (rx_fin && !rx_tot) begin
          if (rx_dat[31:24] == 8'hA5) begin
            m_in = 1;
            m_hcmd = rx_dat[7:0];
            m_q.delete();
          end else merr(2'd1);
        end
      end else if (rx_tot) begin
        merr(2'd0);
        m_in = 0;
      end else if (rx_fin) begin
        if (m_q.size() < N) m_q.push_back(rx_dat);
        else begin
          m_sum = '0;
          foreach (m_q[i]) m_sum += m_q[i];
          if (m_sum == rx_dat) begin
            m_out = 1;
            m_cmd = m_hcmd;
            for (int i = 0; i < N; i++) m_dat[i*32 +: 32] = m_q[i];
          end else merr(2'd2);
          m_in = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("baud", baud, m_baud);
    chk("pkt_vld", pkt_vld, m_out);
    chk("bsy", bsy, m_in | m_out);
    chk("err_pls", err_pls, m_err);
    chk("err_code", err_code, m_code);
    chk("cnt_ok", cnt_ok, m_ok[15:0]);
    chk("cnt_err", cnt_err, m_nerr[15:0]);
    chk("pkt_cmd", pkt_cmd, m_cmd);
    chk("pkt_dat", pkt_dat, m_dat);
  end

  task automatic word(input logic [31:0] d);
    rx_dat = d;
    rx_fin = 1'b1;
    @(negedge clk);
    rx_fin = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_baud", baud, 8'd16);
    chk("rst_bsy", bsy, 1'b0);
    chk("rst_vld", pkt_vld, 1'b0);
    chk("rst_cnt_err", cnt_err, 16'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    // good packet
    word(32'hA500_0012); word(32'd1); word(32'd2); word(32'd3);
    chk("good_vld", pkt_vld, 1'b1);
    chk("good_cmd", pkt_cmd, 8'h12);
    chk("good_dat", pkt_dat, 64'h0000_0002_0000_0001);
    chk("good_no_err", err_pls, 1'b0);
    @(negedge clk);
    chk("good_cnt_ok", cnt_ok, 16'd1);
    chk("good_vld_off", pkt_vld, 1'b0);
    // bad key, then bad checksum
    word(32'h5A00_0000);
    chk("key_code", err_code, 2'd1);
    chk("key_cnt", cnt_err, 16'd1);
    word(32'hA500_0001); word(32'd5); word(32'd6); word(32'h0000_000A);
    chk("sum_code", err_code, 2'd2);
    chk("sum_cnt", cnt_err, 16'd2);
    chk("sum_vld", pkt_vld, 1'b0);
    chk("sum_keep_dat", pkt_dat, 64'h0000_0002_0000_0001);
    // idle timeout ignored, then timeout mid-packet coinciding with a word
    rx_tot = 1'b1; @(negedge clk); rx_tot = 1'b0;
    chk("idle_tot", err_pls, 1'b0);
    word(32'hA500_0000); word(32'd7);
    chk("tot_bsy_pre", bsy, 1'b1);
    rx_dat = 32'd7; rx_fin = 1'b1; rx_tot = 1'b1;
    @(negedge clk);
    rx_fin = 1'b0; rx_tot = 1'b0;
    chk("tot_code", err_code, 2'd0);
    chk("tot_bsy", bsy, 1'b0);
    chk("tot_cnt", cnt_err, 16'd3);
    word(32'hA500_0034); word(32'd10); word(32'd20); word(32'd30);
    chk("after_tot_dat", pkt_dat, {32'd20, 32'd10});
    chk("after_tot_cmd", pkt_cmd, 8'h34);
    @(negedge clk);
    chk("after_tot_ok", cnt_ok, 16'd2);
    // backpressure with overflow word and ignored timeout
    pkt_rdy = 1'b0;
    word(32'hA500_0056); word(32'h100); word(32'h200); word(32'h300);
    repeat (3) @(negedge clk);
    word(32'hDEAD_BEEF);
    chk("ovf_code", err_code, 2'd3);
    chk("ovf_cnt", cnt_err, 16'd4);
    chk("ovf_dat", pkt_dat, {32'h200, 32'h100});
    chk("ovf_vld", pkt_vld, 1'b1);
    rx_tot = 1'b1; @(negedge clk); rx_tot = 1'b0;
    chk("out_tot", err_pls, 1'b0);
    repeat (5) @(negedge clk);
    pkt_rdy = 1'b1;
    @(negedge clk);
    chk("bp_ok", cnt_ok, 16'd3);
    chk("bp_vld", pkt_vld, 1'b0);
    // baud configuration
    cfg_baud = 8'd1; cfg_we = 1'b1; @(negedge clk); cfg_we = 1'b0;
    chk("baud_min", baud, 8'd2);
    cfg_baud = 8'd9; cfg_we = 1'b1;
    word(32'hA500_0000);
    cfg_we = 1'b0;
    chk("baud_hdr", baud, 8'd9);
    cfg_baud = 8'd40; cfg_we = 1'b1; @(negedge clk); cfg_we = 1'b0;
    chk("baud_pld", baud, 8'd9);
    word(32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_baud", baud, 8'd16);
    chk("arst_bsy", bsy, 1'b0);
    chk("arst_ok", cnt_ok, 16'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    // error counter saturation
    rx_dat = 32'h5A00_0000; rx_fin = 1'b1;
    repeat (65535) @(negedge clk);
    rx_fin = 1'b0;
    chk("sat_full", cnt_err, 16'hFFFF);
    for (int k = 0; k < 3; k++) begin
      word(32'h5A00_0000);
      chk("sat_pls", err_pls, 1'b1);
      chk("sat_hold", cnt_err, 16'hFFFF);
      @(negedge clk);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
